// File: rtl/dtc_stub_router.sv
// Stub demultiplexer for the DTC receive path: walks the packed stubs of one CIC packet
// and routes each to the MPA buffer named by its chip ID, tracking per-chip fill and errors.
module dtc_stub_router #(
  parameter int unsigned PKT_W   = 256,
  parameter int unsigned HDR_W   = 26,
  parameter int unsigned STUB_W  = 21,
  parameter int unsigned NSTUB   = 10,
  parameter int unsigned CID_W   = 3,
  parameter int unsigned CID_LSB = 15,
  parameter int unsigned NCHIP   = 8,
  parameter int unsigned ADDR_W  = 7
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          pkt_valid,
  output logic                          pkt_ready,
  input  logic [PKT_W-1:0]              pkt_data,
  input  logic [$clog2(NSTUB+1)-1:0]    pkt_nstub,
  input  logic                          pkt_sof,
  output logic [NCHIP-1:0]              wr_en,
  output logic [ADDR_W-1:0]             wr_addr,
  output logic [STUB_W-1:0]             wr_data,
  output logic [NCHIP*(ADDR_W+1)-1:0]   fill,
  output logic [NCHIP-1:0]              ovf,
  output logic                          cid_err,
  input  logic                          flag_clr
);

  localparam int unsigned DEPTH  = 2 ** ADDR_W;
  localparam int unsigned NW     = $clog2(NSTUB + 1);
  localparam int unsigned FW     = ADDR_W + 1;
  localparam int unsigned BodyW  = PKT_W - HDR_W;
  localparam int unsigned StubsW = NSTUB * STUB_W;

  typedef enum logic [0:0] {StIdle, StScan} state_e;

  state_e                   state_q, state_d;
  logic                     pkt_ready_q;
  logic [StubsW-1:0]        pkt_q, pkt_d;
  logic [NW-1:0]            n_q, n_d, idx_q, idx_d;
  logic [NCHIP-1:0]         wr_en_q, wr_en_d;
  logic [ADDR_W-1:0]        wr_addr_q, wr_addr_d;
  logic [STUB_W-1:0]        wr_data_q, wr_data_d;
  logic [NCHIP-1:0][FW-1:0] fill_q, fill_d;
  logic [NCHIP-1:0]         ovf_q, ovf_d;
  logic                     cid_err_q, cid_err_d;

  logic [NW-1:0]            n_in;
  logic [STUB_W-1:0]        in_stub0, scan_stub, route_stub;
  logic                     route;
  logic [CID_W-1:0]         cid;
  logic                     hit;

  // Header and any padding below the last stub slot carry nothing we route.
  logic unused_bits;
  if (BodyW > StubsW) begin : g_pad
    assign unused_bits = ^{pkt_data[PKT_W-1 -: HDR_W], pkt_data[BodyW-StubsW-1:0]};
  end else begin : g_nopad
    assign unused_bits = ^pkt_data[PKT_W-1 -: HDR_W];
  end

  assign n_in     = (pkt_nstub > NW'(NSTUB)) ? NW'(NSTUB) : pkt_nstub;
  assign in_stub0 = pkt_data[BodyW-1 -: STUB_W];

  always_comb begin
    scan_stub = '0;
    for (int i = 0; i < NSTUB; i++) begin
      if (idx_q == NW'(i)) scan_stub = pkt_q[StubsW-1-i*STUB_W -: STUB_W];
    end
  end

  // Stub 0 is routed on the accept edge straight from pkt_data so its write lands
  // in the cycle right after the handshake; later stubs come from the latched copy.
  always_comb begin
    state_d    = state_q;
    pkt_d      = pkt_q;
    n_d        = n_q;
    idx_d      = idx_q;
    wr_en_d    = '0;
    wr_addr_d  = wr_addr_q;
    wr_data_d  = wr_data_q;
    fill_d     = fill_q;
    ovf_d      = flag_clr ? '0 : ovf_q;
    cid_err_d  = flag_clr ? 1'b0 : cid_err_q;
    route      = 1'b0;
    route_stub = '0;
    cid        = '0;
    hit        = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (pkt_valid && pkt_ready_q) begin
          pkt_d = pkt_data[BodyW-1 -: StubsW];
          n_d   = n_in;
          idx_d = NW'(1);
          if (pkt_sof) fill_d = '0;
          if (n_in != '0) begin
            route      = 1'b1;
            route_stub = in_stub0;
            state_d    = StScan;
          end
        end
      end
      StScan: begin
        if (idx_q >= n_q) begin
          state_d = StIdle;
        end else begin
          route      = 1'b1;
          route_stub = scan_stub;
          idx_d      = idx_q + NW'(1);
        end
      end
      default: state_d = StIdle;
    endcase

    if (route) begin
      cid = route_stub[CID_LSB +: CID_W];
      for (int k = 0; k < NCHIP; k++) begin
        if (cid == CID_W'(k)) begin
          hit = 1'b1;
          if (fill_d[k] == FW'(DEPTH)) begin
            ovf_d[k] = 1'b1;
          end else begin
            wr_en_d[k] = 1'b1;
            wr_addr_d  = fill_d[k][ADDR_W-1:0];
            wr_data_d  = route_stub;
            fill_d[k]  = fill_d[k] + FW'(1);
          end
        end
      end
      if (!hit) cid_err_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      pkt_ready_q <= 1'b0;
      pkt_q       <= '0;
      n_q         <= '0;
      idx_q       <= '0;
      wr_en_q     <= '0;
      wr_addr_q   <= '0;
      wr_data_q   <= '0;
      fill_q      <= '0;
      ovf_q       <= '0;
      cid_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      pkt_ready_q <= (state_d == StIdle);
      pkt_q       <= pkt_d;
      n_q         <= n_d;
      idx_q       <= idx_d;
      wr_en_q     <= wr_en_d;
      wr_addr_q   <= wr_addr_d;
      wr_data_q   <= wr_data_d;
      fill_q      <= fill_d;
      ovf_q       <= ovf_d;
      cid_err_q   <= cid_err_d;
    end
  end

  assign pkt_ready = pkt_ready_q;
  assign wr_en     = wr_en_q;
  assign wr_addr   = wr_addr_q;
  assign wr_data   = wr_data_q;
  assign fill      = fill_q;
  assign ovf       = ovf_q;
  assign cid_err   = cid_err_q;

endmodule

// File: tb/tb_dtc_stub_router.sv
// Scoreboard bench for dtc_stub_router: a default 8-chip instance plus a 6-chip instance
// sharing the same stimulus, used for the out-of-range chip-ID case.
module tb_dtc_stub_router;

  localparam int NS = 10;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         pkt_valid = 1'b0;
  logic         pkt_sof = 1'b0;
  logic         flag_clr = 1'b0;
  logic [255:0] pkt_data = '0;
  logic [3:0]   pkt_nstub = '0;

  logic         pkt_ready, cid_err;
  logic [7:0]   wr_en, ovf;
  logic [6:0]   wr_addr;
  logic [20:0]  wr_data;
  logic [63:0]  fill;

  logic         pkt_ready6, cid_err6;
  logic [5:0]   wr_en6, ovf6;
  logic [6:0]   wr_addr6;
  logic [20:0]  wr_data6;
  logic [47:0]  fill6;

  always #5 clk = ~clk;

  dtc_stub_router u_dut (
    .clk(clk), .rst_n(rst_n), .pkt_valid(pkt_valid), .pkt_ready(pkt_ready),
    .pkt_data(pkt_data), .pkt_nstub(pkt_nstub), .pkt_sof(pkt_sof), .wr_en(wr_en),
    .wr_addr(wr_addr), .wr_data(wr_data), .fill(fill), .ovf(ovf), .cid_err(cid_err),
    .flag_clr(flag_clr)
  );

  dtc_stub_router #(.NCHIP(6)) u_dut6 (
    .clk(clk), .rst_n(rst_n), .pkt_valid(pkt_valid), .pkt_ready(pkt_ready6),
    .pkt_data(pkt_data), .pkt_nstub(pkt_nstub), .pkt_sof(pkt_sof), .wr_en(wr_en6),
    .wr_addr(wr_addr6), .wr_data(wr_data6), .fill(fill6), .ovf(ovf6), .cid_err(cid_err6),
    .flag_clr(flag_clr)
  );

  typedef struct {
    int          cyc;
    int          chip;
    int          addr;
    logic [20:0] data;
  } wr_t;

  wr_t exp_q[$];
  wr_t mon_e;
  int  cyc = 0;
  int  n_cmp = 0;
  int  n_err = 0;
  int  fill_m[8];
  int  fill6_m[6];
  int  cid_tab[NS];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Every DUT write must match the next expected write, including the cycle it lands in.
  always @(negedge clk) begin
    if (rst_n && wr_en !== 8'h00) begin
      if (exp_q.size() == 0) begin
        check("spurious_wr", 64'(wr_en), 64'h0);
      end else begin
        mon_e = exp_q.pop_front();
        check("wr_cyc", 64'(cyc), 64'(mon_e.cyc));
        check("wr_en", 64'(wr_en), 64'(1) << mon_e.chip);
        check("wr_addr", 64'(wr_addr), 64'(mon_e.addr));
        check("wr_data", 64'(wr_data), 64'(mon_e.data));
      end
    end
  end

  task automatic clear_model();
    for (int k = 0; k < 8; k++) fill_m[k] = 0;
    for (int k = 0; k < 6; k++) fill6_m[k] = 0;
  endtask

  // Drives one packet at a negedge once pkt_ready is seen; returns at the next negedge.
  task automatic send(input bit sof, input int nst, input bit keep, output int t_acc);
    logic [255:0] d;
    logic [20:0]  stub;
    int           n;
    int           guard;
    wr_t          e;
    guard = 0;
    while (pkt_ready !== 1'b1 && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 200) check("ready_timeout", 64'(pkt_ready), 64'h1);
    d = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
    n = (nst > NS) ? NS : nst;
    if (sof) clear_model();
    for (int i = 0; i < NS; i++) begin
      stub = 21'($urandom);
      stub[17:15] = 3'(cid_tab[i]);
      d[229-21*i -: 21] = stub;
      if (i < n) begin
        if (fill_m[cid_tab[i]] < 128) begin
          e.cyc  = cyc + 1 + i;
          e.chip = cid_tab[i];
          e.addr = fill_m[cid_tab[i]];
          e.data = stub;
          exp_q.push_back(e);
          fill_m[cid_tab[i]]++;
        end
        if (cid_tab[i] < 6 && fill6_m[cid_tab[i]] < 128) fill6_m[cid_tab[i]]++;
      end
    end
    pkt_data  = d;
    pkt_nstub = 4'(nst);
    pkt_sof   = sof;
    pkt_valid = 1'b1;
    t_acc     = cyc;
    @(negedge clk);
    if (!keep) pkt_valid = 1'b0;
  endtask

  task automatic wait_ready(output int c);
    int g;
    g = 0;
    while (pkt_ready !== 1'b1 && g < 200) begin
      @(negedge clk);
      g++;
    end
    c = cyc;
  endtask

  task automatic check_fill();
    for (int k = 0; k < 8; k++) check("fill", 64'(fill[k*8 +: 8]), 64'(fill_m[k]));
    for (int k = 0; k < 6; k++) check("fill6", 64'(fill6[k*8 +: 8]), 64'(fill6_m[k]));
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int t, c;
    int ta[4];
    int exp_f[8];
    exp_f = '{2, 2, 1, 1, 1, 1, 1, 1};
    clear_model();

    // Reset values
    @(negedge clk);
    @(negedge clk);
    check("rst_ready", 64'(pkt_ready), 64'h0);
    check("rst_wr_en", 64'(wr_en), 64'h0);
    check("rst_wr_addr", 64'(wr_addr), 64'h0);
    check("rst_wr_data", 64'(wr_data), 64'h0);
    check("rst_fill", fill, 64'h0);
    check("rst_ovf", 64'(ovf), 64'h0);
    check("rst_cid_err", 64'(cid_err), 64'h0);
    rst_n = 1'b1;
    check("ready_at_release", 64'(pkt_ready), 64'h0);
    @(negedge clk);
    check("ready_after_release", 64'(pkt_ready), 64'h1);

    // Full packet, chips 0..7,0,1
    for (int i = 0; i < NS; i++) cid_tab[i] = i % 8;
    send(1'b1, 10, 1'b0, t);
    wait_ready(c);
    check("ready_rise_n10", 64'(c), 64'(t + 11));
    for (int k = 0; k < 8; k++) check("fill_n10", 64'(fill[k*8 +: 8]), 64'(exp_f[k]));

    // Asynchronous reset in the middle of a scan
    send(1'b1, 10, 1'b0, t);
    @(negedge clk);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("midrst_wr_en", 64'(wr_en), 64'h0);
    check("midrst_fill", fill, 64'h0);
    check("midrst_ovf", 64'(ovf), 64'h0);
    check("midrst_ready", 64'(pkt_ready), 64'h0);
    exp_q.delete();
    clear_model();
    @(negedge clk);
    rst_n = 1'b1;
    check("midrst_ready_rel", 64'(pkt_ready), 64'h0);
    @(negedge clk);
    check("midrst_ready_rise", 64'(pkt_ready), 64'h1);

    // Some fill, then an empty start-of-frame packet, then an over-long nstub
    for (int i = 0; i < NS; i++) cid_tab[i] = $urandom_range(0, 7);
    send(1'b0, 5, 1'b0, t);
    wait_ready(c);
    send(1'b1, 0, 1'b0, t);
    check("n0_ready", 64'(pkt_ready), 64'h1);
    check("n0_fill", fill, 64'h0);
    for (int i = 0; i < NS; i++) cid_tab[i] = $urandom_range(0, 7);
    send(1'b0, 15, 1'b0, t);
    wait_ready(c);
    check("n15_ready_rise", 64'(c), 64'(t + 11));
    check("n15_drained", 64'(exp_q.size()), 64'h0);
    check_fill();

    // Chip ID beyond the 6-chip instance
    flag_clr = 1'b1;
    @(negedge clk);
    flag_clr = 1'b0;
    check("cid_err6_cleared", 64'(cid_err6), 64'h0);
    cid_tab[0] = 7;
    send(1'b0, 1, 1'b0, t);
    check("cid_err6_set", 64'(cid_err6), 64'h1);
    check("cid_err8_clear", 64'(cid_err), 64'h0);
    wait_ready(c);
    check_fill();

    // Fill chip 3 to the top, then overflow it
    for (int i = 0; i < NS; i++) cid_tab[i] = 3;
    send(1'b1, 10, 1'b0, t);
    for (int p = 0; p < 11; p++) send(1'b0, 10, 1'b0, t);
    send(1'b0, 8, 1'b0, t);
    wait_ready(c);
    check("fill3_full", 64'(fill[3*8 +: 8]), 64'd128);
    check("ovf_before", 64'(ovf), 64'h0);
    send(1'b0, 3, 1'b0, t);
    wait_ready(c);
    check("fill3_sat", 64'(fill[3*8 +: 8]), 64'd128);
    check("ovf_set", 64'(ovf), 64'h08);
    check("ovf6_set", 64'(ovf6), 64'h08);
    repeat (3) @(negedge clk);
    check("ovf_sticky", 64'(ovf), 64'h08);
    flag_clr = 1'b1;
    @(negedge clk);
    flag_clr = 1'b0;
    check("ovf_clr", 64'(ovf), 64'h0);
    flag_clr = 1'b1;
    send(1'b0, 1, 1'b0, t);
    check("ovf_set_wins", 64'(ovf), 64'h08);
    @(negedge clk);
    check("ovf_clr_after", 64'(ovf), 64'h0);
    flag_clr = 1'b0;

    // Back-to-back 4-stub packets with pkt_valid held
    for (int p = 0; p < 4; p++) begin
      for (int i = 0; i < NS; i++) cid_tab[i] = $urandom_range(0, 7);
      send(p == 0, 4, 1'b1, ta[p]);
    end
    pkt_valid = 1'b0;
    for (int p = 1; p < 4; p++) check("b2b_interval", 64'(ta[p] - ta[p-1]), 64'd5);

    repeat (15) @(negedge clk);
    check("queue_drained", 64'(exp_q.size()), 64'h0);
    check_fill();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
